// File: rtl/alu_issue_if.sv
// ----------------------------------------------------------------------------
// alu_issue_if
// Bundles every handshake/bus signal of alu_issue.
//   request  : in_valid, in_ready, in_aluop, in_funct3, in_funct7_5, in_a, in_b
//   ALU side : alu_a, alu_b, alu_ctl (to ALU); alu_result, alu_zero,
//              alu_overflow (combinational ALU outputs back)
//   response : out_valid, out_ready, out_result, out_zero, out_overflow,
//              out_illegal, out_ovf_sticky
// master = requester + ALU environment, slave = alu_issue.
// ----------------------------------------------------------------------------
interface alu_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_aluop;
    logic [2:0]  in_funct3;
    logic        in_funct7_5;
    logic [31:0] in_a;
    logic [31:0] in_b;

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctl;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_overflow;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_overflow;
    logic        out_illegal;
    logic        out_ovf_sticky;

    modport master (
        output in_valid, in_aluop, in_funct3, in_funct7_5, in_a, in_b,
        output alu_result, alu_zero, alu_overflow, out_ready,
        input  in_ready, alu_a, alu_b, alu_ctl,
        input  out_valid, out_result, out_zero, out_overflow, out_illegal,
        input  out_ovf_sticky
    );

    modport slave (
        input  in_valid, in_aluop, in_funct3, in_funct7_5, in_a, in_b,
        input  alu_result, alu_zero, alu_overflow, out_ready,
        output in_ready, alu_a, alu_b, alu_ctl,
        output out_valid, out_result, out_zero, out_overflow, out_illegal,
        output out_ovf_sticky
    );
endinterface

// File: rtl/alu_issue.sv
// ----------------------------------------------------------------------------
// alu_issue
// Decodes a RISC-style ALU request (aluop/funct3/funct7[5]) into a 4-bit ALU
// control word, presents registered operands to an external combinational
// ALU for one EXEC cycle, captures its result and holds it on a valid/ready
// response port.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - alu_issue_if.slave (request, ALU and response signals)
//
// Configuration macro:
//   ALU_ISSUE_STICKY_OVF_EN - when defined, out_ovf_sticky latches any
//   captured overflow until reset; otherwise it is tied to 0.
// ----------------------------------------------------------------------------
module alu_issue (
    input  logic        clk,
    input  logic        rst,
    alu_issue_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_in_ready;
    logic [31:0] r_alu_a;
    logic [31:0] r_alu_b;
    logic [3:0]  r_alu_ctl;
    logic        r_illegal;
    logic        r_out_valid;
    logic [31:0] r_out_result;
    logic        r_out_zero;
    logic        r_out_overflow;
    logic        r_out_illegal;

    logic [3:0]  w_dec_ctl;
    logic        w_dec_illegal;
    logic        w_cap_ovf;

    // Request decode. Illegal combinations still drive the ADD code so the
    // ALU sees a harmless operation; the result is overridden at capture.
    always_comb begin
        w_dec_ctl     = 4'b0010;
        w_dec_illegal = 1'b0;
        case (bus.in_aluop)
            2'b00: w_dec_ctl = 4'b0010;
            2'b01: w_dec_ctl = 4'b0110;
            2'b10: begin
                case (bus.in_funct3)
                    3'b000:  w_dec_ctl = bus.in_funct7_5 ? 4'b0110 : 4'b0010;
                    3'b111:  w_dec_ctl = 4'b0000;
                    3'b110:  w_dec_ctl = 4'b0001;
                    3'b010:  w_dec_ctl = 4'b0111;
                    default: w_dec_illegal = 1'b1;
                endcase
            end
            default: w_dec_illegal = 1'b1;
        endcase
    end

    // Arithmetic codes (ADD/SUB/SLT) all have ctl[1]=1; logical ones do not,
    // so ctl[1] alone selects whether ALU overflow is meaningful.
    assign w_cap_ovf = !r_illegal && r_alu_ctl[1] && bus.alu_overflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_in_ready     <= 1'b1;
            r_alu_a        <= 32'd0;
            r_alu_b        <= 32'd0;
            r_alu_ctl      <= 4'b0000;
            r_illegal      <= 1'b0;
            r_out_valid    <= 1'b0;
            r_out_result   <= 32'd0;
            r_out_zero     <= 1'b0;
            r_out_overflow <= 1'b0;
            r_out_illegal  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_alu_a    <= bus.in_a;
                        r_alu_b    <= bus.in_b;
                        r_alu_ctl  <= w_dec_ctl;
                        r_illegal  <= w_dec_illegal;
                        r_in_ready <= 1'b0;
                        r_state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (r_illegal) begin
                        r_out_result   <= 32'd0;
                        r_out_zero     <= 1'b1;
                        r_out_overflow <= 1'b0;
                        r_out_illegal  <= 1'b1;
                    end else begin
                        r_out_result   <= bus.alu_result;
                        r_out_zero     <= bus.alu_zero;
                        r_out_overflow <= w_cap_ovf;
                        r_out_illegal  <= 1'b0;
                    end
                    r_out_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ALU_ISSUE_STICKY_OVF_EN
    logic r_ovf_sticky;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_sticky <= 1'b0;
        end else if (r_state == S_EXEC && w_cap_ovf) begin
            r_ovf_sticky <= 1'b1;
        end
    end

    assign bus.out_ovf_sticky = r_ovf_sticky;
`else
    assign bus.out_ovf_sticky = 1'b0;
`endif

    assign bus.in_ready     = r_in_ready;
    assign bus.alu_a        = r_alu_a;
    assign bus.alu_b        = r_alu_b;
    assign bus.alu_ctl      = r_alu_ctl;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_result   = r_out_result;
    assign bus.out_zero     = r_out_zero;
    assign bus.out_overflow = r_out_overflow;
    assign bus.out_illegal  = r_out_illegal;

endmodule
